// File: rtl/jtag_user_dr_ctrl.sv
// rtl/jtag_user_dr_ctrl.sv - JTAG ER1 user data register bridged to a single-request register bus
module jtag_user_dr_ctrl #(
    parameter int ADDR_W  = 6,    // at most 6: address field of the DR is 6 bits
    parameter int TIMEOUT = 255   // tck cycles to wait for bus_ack, 1..255
) (
    input  logic              tck,
    input  logic              test_logic_reset,
    input  logic              tdi,
    input  logic              shift_dr_capture_dr,
    input  logic              update_dr,
    input  logic              enable_er1,
    output logic              tdo_er1,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    logic [39:0] sr;
    logic        sdc_d;
    state_t      state;
    logic [7:0]  timer;
    logic [31:0] rdata_q;
    logic        ovr;
    logic        err;

    logic       capture;
    logic       shift;
    logic       update;
    logic       busy;
    logic [1:0] op;

    // The GW_JTAG strobe covers both capture and shift; its first cycle is the capture.
    assign capture = enable_er1 & shift_dr_capture_dr & ~sdc_d;
    assign shift   = enable_er1 & shift_dr_capture_dr & sdc_d;
    assign update  = enable_er1 & update_dr;
    assign busy    = (state == REQ);
    assign op      = sr[39:38];
    assign tdo_er1 = sr[0];

    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            sr    <= '0;
            sdc_d <= 1'b0;
        end else begin
            sdc_d <= shift_dr_capture_dr;
            if (capture) begin
                sr <= {ovr, err, busy, 5'b0, rdata_q};
            end else if (shift) begin
                sr <= {tdi, sr[39:1]};
            end
        end
    end

    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata_q   <= '0;
            timer     <= '0;
            ovr       <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (update) begin
                        case (op)
                            2'b01, 2'b10: begin
                                bus_addr  <= sr[32 +: ADDR_W];
                                bus_wdata <= sr[31:0];
                                bus_we    <= op[0];
                                timer     <= TIMEOUT_L;
                                bus_req   <= 1'b1;
                                state     <= REQ;
                            end
                            2'b11: begin
                                ovr <= 1'b0;
                                err <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                REQ: begin
                    // A new command cannot be queued; flag it and let the bus cycle finish.
                    if (update) begin
                        ovr <= 1'b1;
                    end
                    if (bus_ack) begin
                        if (!bus_we) begin
                            rdata_q <= bus_rdata;
                        end
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end else if (timer == 8'd1) begin
                        err     <= 1'b1;
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: begin
                    bus_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_user_dr_ctrl.sv
// tb/tb_jtag_user_dr_ctrl.sv - self-checking bench for jtag_user_dr_ctrl
module tb_jtag_user_dr_ctrl;

    localparam int TMO = 4;

    logic        tck = 1'b0;
    logic        test_logic_reset = 1'b1;
    logic        tdi = 1'b0;
    logic        shift_dr_capture_dr = 1'b0;
    logic        update_dr = 1'b0;
    logic        enable_er1 = 1'b0;
    logic        tdo_er1;
    logic        bus_req;
    logic        bus_we;
    logic [5:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference state
    logic        m_ovr, m_err;
    logic [31:0] m_rdata;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  addr;
        logic [31:0] data;
        int          delay;
        logic [31:0] rdata;
        int          exp_cycles;
        logic [39:0] exp_status;
    } vec_t;

    vec_t vecs[7];

    jtag_user_dr_ctrl #(.ADDR_W(6), .TIMEOUT(TMO)) dut (
        .tck                 (tck),
        .test_logic_reset    (test_logic_reset),
        .tdi                 (tdi),
        .shift_dr_capture_dr (shift_dr_capture_dr),
        .update_dr           (update_dr),
        .enable_er1          (enable_er1),
        .tdo_er1             (tdo_er1),
        .bus_req             (bus_req),
        .bus_we              (bus_we),
        .bus_addr            (bus_addr),
        .bus_wdata           (bus_wdata),
        .bus_ack             (bus_ack),
        .bus_rdata           (bus_rdata)
    );

    always #5 tck = ~tck;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    // Capture, 40 shifts (LSB first), then optionally an update.
    task automatic scan(input logic [39:0] din, input bit do_update, output logic [39:0] dout);
        enable_er1 = 1'b1;
        shift_dr_capture_dr = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            tdi = din[i];
            dout[i] = tdo_er1;
            tick();
        end
        shift_dr_capture_dr = 1'b0;
        tdi = 1'b0;
        update_dr = do_update;
        tick();
        update_dr = 1'b0;
    endtask

    // Bus responder: acks on the delay-th request cycle, then pokes an idle ack.
    task automatic serve(input int delay, input logic [31:0] rd, input logic exp_we,
                         input logic [5:0] exp_addr, input logic [31:0] exp_wdata,
                         output int cycles);
        bit stable_ok;
        stable_ok = 1'b1;
        cycles = 0;
        while (bus_req === 1'b1 && cycles < 300) begin
            if (bus_we !== exp_we || bus_addr !== exp_addr || bus_wdata !== exp_wdata)
                stable_ok = 1'b0;
            bus_rdata = (cycles == delay) ? rd : $urandom;
            bus_ack = (cycles == delay);
            tick();
            bus_ack = 1'b0;
            cycles++;
        end
        if (cycles > 0) check("bus_fields_stable", 64'(stable_ok), 64'd1);
        bus_rdata = $urandom;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
    endtask

    function automatic logic [39:0] model_status();
        return {m_ovr, m_err, 1'b0, 5'b0, m_rdata};
    endfunction

    task automatic model_apply(input logic [1:0] op, input int delay, input logic [31:0] rd,
                               output int exp_cycles);
        exp_cycles = 0;
        if (op == 2'b01 || op == 2'b10) begin
            exp_cycles = (delay < TMO) ? delay + 1 : TMO;
            if (delay >= TMO) m_err = 1'b1;
            else if (op == 2'b10) m_rdata = rd;
        end else if (op == 2'b11) begin
            m_ovr = 1'b0;
            m_err = 1'b0;
        end
    endtask

    initial begin
        logic [39:0] d;
        logic [39:0] st;
        logic [39:0] din_g;
        int          cyc;
        int          exp_cyc;
        bit          gate_ok;

        vecs[0] = '{2'b01, 6'h05, 32'hDEADBEEF, 1,  32'h0,        2, 40'h00_00000000};
        vecs[1] = '{2'b10, 6'h2A, 32'h0,        0,  32'h12345678, 1, 40'h00_12345678};
        vecs[2] = '{2'b10, 6'h11, 32'h0,        9,  32'h0,        4, 40'h40_12345678};
        vecs[3] = '{2'b00, 6'h22, 32'h55555555, 0,  32'h0,        0, 40'h40_12345678};
        vecs[4] = '{2'b01, 6'h3F, 32'h01020304, 3,  32'hFFFFFFFF, 4, 40'h40_12345678};
        vecs[5] = '{2'b11, 6'h00, 32'h0,        0,  32'h0,        0, 40'h00_12345678};
        vecs[6] = '{2'b10, 6'h00, 32'h0,        3,  32'hA5A5A5A5, 4, 40'h00_A5A5A5A5};

        // Reset state
        repeat (2) @(posedge tck);
        #1;
        check("reset_bus_req", 64'(bus_req), 64'd0);
        check("reset_bus_we", 64'(bus_we), 64'd0);
        check("reset_bus_addr", 64'(bus_addr), 64'd0);
        check("reset_bus_wdata", 64'(bus_wdata), 64'd0);
        check("reset_tdo", 64'(tdo_er1), 64'd0);
        test_logic_reset = 1'b0;
        tick();

        // Directed table
        foreach (vecs[i]) begin
            scan({vecs[i].op, vecs[i].addr, vecs[i].data}, 1'b1, d);
            if (vecs[i].op == 2'b01 || vecs[i].op == 2'b10)
                check("req_after_update", 64'(bus_req), 64'd1);
            serve(vecs[i].delay, vecs[i].rdata, vecs[i].op[0], vecs[i].addr, vecs[i].data, cyc);
            check($sformatf("vec%0d_req_cycles", i), 64'(cyc), 64'(vecs[i].exp_cycles));
            scan(40'h0, 1'b0, st);
            check($sformatf("vec%0d_status", i), 64'(st), 64'(vecs[i].exp_status));
        end

        // Overrun: capture + one shift during REQ then update, ack in the last timer cycle
        scan({2'b01, 6'h05, 32'h0BADF00D}, 1'b1, d);
        check("ovr_req_start", 64'(bus_req), 64'd1);
        shift_dr_capture_dr = 1'b1;
        tick();
        tdi = 1'b1;
        tick();
        shift_dr_capture_dr = 1'b0;
        tdi = 1'b0;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        check("ovr_req_held", 64'(bus_req), 64'd1);
        check("ovr_addr_kept", 64'(bus_addr), 64'h05);
        check("ovr_we_kept", 64'(bus_we), 64'd1);
        check("ovr_wdata_kept", 64'(bus_wdata), 64'h0BADF00D);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("ovr_ack_done", 64'(bus_req), 64'd0);
        tick();
        check("ovr_no_restart", 64'(bus_req), 64'd0);
        scan(40'h0, 1'b0, st);
        check("ovr_status", 64'(st), 64'h80_A5A5A5A5);

        // Select gating: SR loaded with a write, then strobes with enable_er1 = 0
        din_g = {2'b01, 6'h15, 32'hCAFEF00D};
        scan(din_g, 1'b0, st);
        check("gate_pre_status", 64'(st), 64'h80_A5A5A5A5);
        gate_ok = 1'b1;
        enable_er1 = 1'b0;
        shift_dr_capture_dr = 1'b1;
        for (int i = 0; i < 41; i++) begin
            tdi = 1'($urandom);
            tick();
            if (tdo_er1 !== din_g[0]) gate_ok = 1'b0;
        end
        shift_dr_capture_dr = 1'b0;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus_req !== 1'b0) gate_ok = 1'b0;
            tick();
        end
        check("gate_sr_and_req", 64'(gate_ok), 64'd1);
        check("gate_addr_kept", 64'(bus_addr), 64'h05);
        enable_er1 = 1'b1;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        check("gate_sr_intact_req", 64'(bus_req), 64'd1);
        serve(0, 32'h0, 1'b1, 6'h15, 32'hCAFEF00D, cyc);
        check("gate_txn_cycles", 64'(cyc), 64'd1);

        // Reset mid-transaction
        scan({2'b01, 6'h2C, 32'h13579BDF}, 1'b1, d);
        check("rst_req_before", 64'(bus_req), 64'd1);
        #2;
        test_logic_reset = 1'b1;
        #1;
        check("rst_async_req", 64'(bus_req), 64'd0);
        check("rst_async_we", 64'(bus_we), 64'd0);
        check("rst_async_addr", 64'(bus_addr), 64'd0);
        check("rst_async_wdata", 64'(bus_wdata), 64'd0);
        check("rst_async_tdo", 64'(tdo_er1), 64'd0);
        repeat (2) @(posedge tck);
        #1;
        test_logic_reset = 1'b0;
        tick();
        scan(40'h0, 1'b0, st);
        check("rst_capture_zero", 64'(st), 64'd0);

        // Randomized commands against the transaction model
        m_ovr = 1'b0;
        m_err = 1'b0;
        m_rdata = '0;
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [5:0]  addr;
            logic [31:0] data;
            logic [31:0] rd;
            int          delay;
            op = 2'($urandom);
            addr = 6'($urandom);
            data = $urandom;
            rd = $urandom;
            delay = $urandom_range(0, 6);
            scan({op, addr, data}, 1'b1, d);
            check($sformatf("rand%0d_status", n), 64'(d), 64'(model_status()));
            model_apply(op, delay, rd, exp_cyc);
            serve(delay, rd, op[0], addr, data, cyc);
            check($sformatf("rand%0d_cycles", n), 64'(cyc), 64'(exp_cyc));
        end
        scan(40'h0, 1'b0, st);
        check("rand_final_status", 64'(st), 64'(model_status()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_user_dr_ctrl.md
JTAG_USER_DR_CTRL -- requirements
Module: jtag_user_dr_ctrl

Interface
REQ-001 SHALL take parameter ADDR_W, default 6, as the register-bus address width; ADDR_W <= 6.
REQ-002 SHALL take parameter TIMEOUT, default 255, as the number of tck cycles to wait for bus_ack before abort; legal range 1..255.
REQ-003 SHALL have port tck, input, 1, the single clock, driven from the GW_JTAG tck_o output.
REQ-004 SHALL have port test_logic_reset, input, 1, the asynchronous active-high reset, driven from test_logic_reset_o.
REQ-005 SHALL have port tdi, input, 1, serial data in.
REQ-006 SHALL have port shift_dr_capture_dr, input, 1, the combined capture/shift strobe.
REQ-007 SHALL have port update_dr, input, 1, the update strobe.
REQ-008 SHALL have port enable_er1, input, 1, the ER1 user-register select.
REQ-009 SHALL have port tdo_er1, output, 1, serial data out.
REQ-010 SHALL have port bus_req, output, 1, register-bus request.
REQ-011 SHALL have port bus_we, output, 1, bus direction: 1 = write.
REQ-012 SHALL have port bus_addr, output, ADDR_W, bus address.
REQ-013 SHALL have port bus_wdata, output, 32, bus write data.
REQ-014 SHALL have port bus_ack, input, 1, one-cycle bus completion pulse.
REQ-015 SHALL have port bus_rdata, input, 32, bus read data, valid while bus_ack = 1.

Function
REQ-016 SHALL hold a 40-bit shift register SR, encoded [39:38] op, [37:32] addr, [31:0] data; op values: 00 nop, 01 write, 10 read, 11 clear-status.
REQ-017 SHALL register the sampled strobe as sdc_d; a capture cycle is enable_er1 & shift_dr_capture_dr & ~sdc_d; a shift cycle is enable_er1 & shift_dr_capture_dr & sdc_d.
REQ-018 SHALL, on a capture cycle, load SR with {ovr, err, busy, 5'b0, rdata_q}.
REQ-019 SHALL, on a shift cycle, load SR with {tdi, SR[39:1]}, shifting LSB first.
REQ-020 SHALL drive tdo_er1 = SR[0] combinationally.
REQ-021 SHALL decode SR on update_dr & enable_er1 (an update) and do nothing on update_dr when enable_er1 = 0.
REQ-022 SHALL implement FSM IDLE -> REQ -> IDLE; busy = (state == REQ).
REQ-023 SHALL, in IDLE on an update with op 01 or 10: latch bus_addr = SR[32+ADDR_W-1:32], bus_wdata = SR[31:0], bus_we = op[0]; load timer = TIMEOUT; go to REQ.
REQ-024 SHALL, in IDLE on an update with op 11, clear ovr and err in the same cycle and not change state.
REQ-025 SHALL, in IDLE on an update with op 00, have no effect.
REQ-026 SHALL assert bus_req = 1 only in REQ, registered, starting the cycle after the update; bus_addr, bus_we and bus_wdata SHALL stay stable for the whole REQ state.
REQ-027 SHALL, in REQ when bus_ack = 1: for a read, set rdata_q = bus_rdata; for a write, leave rdata_q unchanged; go to IDLE.
REQ-028 SHALL, in REQ when bus_ack = 0, decrement timer; when timer = 1 and bus_ack = 0, set err = 1 and go to IDLE.
REQ-029 SHALL treat bus_ack in the timer = 1 cycle as a normal completion, with no err.
REQ-030 SHALL ignore bus_ack while in IDLE.
REQ-031 SHALL, on any update while in REQ, set ovr = 1 and discard the command; the current transaction continues unaffected.
REQ-032 SHALL let capture/shift of SR proceed independently of the FSM; a capture while busy reports busy = 1 and the previous rdata_q.
REQ-033 SHALL keep ovr and err sticky until an op 11 update or reset.

Reset
REQ-034 SHALL, while test_logic_reset = 1, asynchronously set: SR = 0, sdc_d = 0, state = IDLE, bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, rdata_q = 0, timer = 0, ovr = 0, err = 0; tdo_er1 = 0 follows.
REQ-035 SHALL, on reset asserted mid-transaction, drop bus_req immediately and abandon the transaction with no flag set.

Verification
REQ-036 SHALL verify write: shift op01, addr 0x05, data 0xDEADBEEF, then update -> next cycle bus_req = 1, bus_we = 1, bus_addr = 0x05, bus_wdata = 0xDEADBEEF; after bus_ack, bus_req = 0.
REQ-037 SHALL verify read: op10, addr 0x2A; respond with bus_ack and bus_rdata = 0x12345678; next capture+shift -> tdo yields 0x12345678 in bits 0..31, then 0, 0, 0, 0, 0, busy = 0, err = 0, ovr = 0.
REQ-038 SHALL verify timeout: TIMEOUT = 4, read with no bus_ack -> bus_req high exactly 4 cycles, then err = 1 in the captured status bit 38; an op11 update clears it.
REQ-039 SHALL verify overrun: second update while busy -> ovr = 1, bus_addr unchanged, and the first transaction completes on bus_ack.
REQ-040 SHALL verify select gating: shift and update with enable_er1 = 0 -> SR and bus outputs unchanged and bus_req = 0.
REQ-041 SHALL verify reset mid-REQ: assert test_logic_reset with bus_req = 1 -> bus_req = 0 asynchronously, all outputs and flags at reset values, and the next capture reads all-zero.
